yiq_composite_encoder: RTL and testbench

Converts the offset-binary YIQ pixel stream into an 8-bit NTSC composite sample stream at 4× subcarrier rate. Per pixel it adds quadrature-modulated chroma onto scaled luma, inserts sync, blanking and colour burst, and inverts the subcarrier on alternate lines. It sits directly downstream of the RGB→YIQ converter and feeds the composite DAC / CRT signal model. Upstream delays de/hsync/vsync to align them with its y/i/q outputs.

---
 rtl/yiq_composite_encoder.sv | 191 +++++++++++++++++++
 tb/tb_yiq_composite_encoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/yiq_composite_encoder.sv
// Offset-binary YIQ to 8-bit NTSC composite at 4x fsc: luma plus quadrature chroma,
// with sync, blanking, colour burst and per-line subcarrier inversion. Two-stage pipeline.
module yiq_composite_encoder #(
    parameter logic [7:0] SYNC_LVL    = 8'd0,
    parameter logic [7:0] BLANK_LVL   = 8'd64,
    parameter logic [7:0] BURST_AMP   = 8'd20,
    parameter logic [7:0] BURST_START = 8'd8,
    parameter logic [7:0] BURST_LEN   = 8'd36
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] y,
    input  logic [7:0] i,
    input  logic [7:0] q,
    input  logic       de,
    input  logic       hsync,
    input  logic       vsync,
    output logic [7:0] composite,
    output logic       out_de,
    output logic       out_hsync
);

    typedef enum logic [1:0] {
        CLS_BLANK  = 2'd0,
        CLS_ACTIVE = 2'd1,
        CLS_BURST  = 2'd2,
        CLS_SYNC   = 2'd3
    } cls_t;

    logic [7:0] pc;
    logic [1:0] ph;
    logic       alt;
    logic       hs_prev;
    logic       vs_prev;

    logic       hs_fall;
    logic       hs_rise;
    logic       vs_rise;
    logic [7:0] pc_cur;
    logic [1:0] ph_cur;
    logic       alt_cur;
    logic [1:0] e_ph;

    assign hs_fall = hs_prev & ~hsync;
    assign hs_rise = ~hs_prev & hsync;
    assign vs_rise = ~vs_prev & vsync;

    // Line counters as seen by the sample currently on the inputs; the registers
    // hold these same values one cycle later.
    always_comb begin
        pc_cur = pc;
        if (hsync)
            pc_cur = 8'hFF;
        else if (hs_fall)
            pc_cur = 8'd0;
        else if (pc != 8'hFF)
            pc_cur = pc + 8'd1;
        ph_cur  = hs_fall ? 2'd0 : ph + 2'd1;
        alt_cur = vs_rise ? 1'b0 : (hs_rise ? ~alt : alt);
    end

    assign e_ph = ph_cur + {alt_cur, 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= 8'hFF;
            ph      <= 2'd0;
            alt     <= 1'b0;
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            pc      <= pc_cur;
            ph      <= ph_cur;
            alt     <= alt_cur;
            hs_prev <= hsync;
            vs_prev <= vsync;
        end
    end

    logic        [9:0] y3;
    logic        [9:0] luma;
    logic signed [8:0] i_off;
    logic signed [8:0] q_off;
    logic signed [8:0] i_half;
    logic signed [8:0] q_half;
    logic signed [8:0] chroma_sel;
    logic        [7:0] burst_val;
    logic        [8:0] burst_end;
    logic              in_burst;
    cls_t              cls_next;

    assign y3     = {2'b00, y} + {1'b0, y, 1'b0};
    assign luma   = {2'b00, BLANK_LVL} + (y3 >> 2);
    assign i_off  = $signed({1'b0, i}) - 9'sd128;
    assign q_off  = $signed({1'b0, q}) - 9'sd128;
    assign i_half = i_off >>> 1;
    assign q_half = q_off >>> 1;

    assign burst_end = {1'b0, BURST_START} + {1'b0, BURST_LEN};
    assign in_burst  = ({1'b0, pc_cur} >= {1'b0, BURST_START}) && ({1'b0, pc_cur} < burst_end);

    always_comb begin
        chroma_sel = i_half;
        burst_val  = BLANK_LVL;
        case (e_ph)
            2'd0: begin
                chroma_sel = i_half;
                burst_val  = BLANK_LVL + BURST_AMP;
            end
            2'd1: chroma_sel = q_half;
            2'd2: begin
                chroma_sel = -i_half;
                burst_val  = BLANK_LVL - BURST_AMP;
            end
            default: chroma_sel = -q_half;
        endcase
    end

    // Burst outranks de: a pixel arriving inside the burst window is dropped.
    always_comb begin
        cls_next = CLS_BLANK;
        if (hsync || vsync)
            cls_next = CLS_SYNC;
        else if (in_burst)
            cls_next = CLS_BURST;
        else if (de)
            cls_next = CLS_ACTIVE;
    end

    logic        [9:0] luma_r;
    logic signed [8:0] chroma_r;
    logic        [7:0] burst_r;
    cls_t              cls_r;
    logic              de_r;
    logic              hs_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            luma_r   <= 10'd0;
            chroma_r <= 9'sd0;
            burst_r  <= 8'd0;
            cls_r    <= CLS_BLANK;
            de_r     <= 1'b0;
            hs_r     <= 1'b0;
        end else begin
            luma_r   <= luma;
            chroma_r <= chroma_sel;
            burst_r  <= burst_val;
            cls_r    <= cls_next;
            de_r     <= de;
            hs_r     <= hsync;
        end
    end

    logic signed [9:0] sum;
    logic        [7:0] active_val;
    logic        [7:0] comp_next;

    assign sum = $signed(luma_r) + $signed({chroma_r[8], chroma_r});

    always_comb begin
        active_val = sum[7:0];
        if (sum < 10'sd0)
            active_val = 8'd0;
        else if (sum > 10'sd255)
            active_val = 8'd255;
    end

    always_comb begin
        comp_next = BLANK_LVL;
        case (cls_r)
            CLS_SYNC:   comp_next = SYNC_LVL;
            CLS_BURST:  comp_next = burst_r;
            CLS_ACTIVE: comp_next = active_val;
            default:    comp_next = BLANK_LVL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            composite <= BLANK_LVL;
            out_de    <= 1'b0;
            out_hsync <= 1'b0;
        end else begin
            composite <= comp_next;
            out_de    <= de_r;
            out_hsync <= hs_r;
        end
    end

endmodule

// File: tb/tb_yiq_composite_encoder.sv
// Bench for yiq_composite_encoder: a cycle-level reference model built from the line
// timing rules, compared every cycle, plus hand-computed literal samples per line.
module tb_yiq_composite_encoder;

    localparam int HS_LEN  = 10;
    localparam int LINE    = 70;
    localparam int DE_FROM = HS_LEN + 48;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] y = 8'd0;
    logic [7:0] i = 8'd128;
    logic [7:0] q = 8'd128;
    logic       de = 1'b0;
    logic       hsync = 1'b0;
    logic       vsync = 1'b0;
    logic [7:0] composite;
    logic       out_de;
    logic       out_hsync;

    yiq_composite_encoder dut (
        .clk(clk),
        .rst(rst),
        .y(y),
        .i(i),
        .q(q),
        .de(de),
        .hsync(hsync),
        .vsync(vsync),
        .composite(composite),
        .out_de(out_de),
        .out_hsync(out_hsync)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;
    int lit [0:127];

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int model_sample(input int yv, input int iv, input int qv,
                                        input bit dv, input bit hv, input bit vv,
                                        input int pcv, input int ev);
        int l, c, ip, qp, v;
        if (hv || vv) return 0;
        if (pcv >= 8 && pcv < 8 + 36) begin
            if (ev == 0) return 64 + 20;
            if (ev == 2) return 64 - 20;
            return 64;
        end
        if (!dv) return 64;
        l  = 64 + (3 * yv) / 4;
        ip = (iv - 128) >>> 1;
        qp = (qv - 128) >>> 1;
        case (ev)
            0:       c = ip;
            1:       c = qp;
            2:       c = -ip;
            default: c = -qp;
        endcase
        v = l + c;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        return v;
    endfunction

    // Model: time since the last hsync fall defines pc and phase; alt follows sync edges.
    int m_ticks;
    bit m_seen_fall;
    bit m_alt;
    bit m_prev_h;
    bit m_prev_v;
    int exp1_c, exp2_c;
    bit exp1_de, exp2_de, exp1_hs, exp2_hs;

    always @(posedge clk) begin
        int pcv, ev;
        bit fall, rise, vrise;
        if (rst) begin
            m_ticks = 0;
            m_seen_fall = 1'b0;
            m_alt = 1'b0;
            m_prev_h = 1'b0;
            m_prev_v = 1'b0;
            exp1_c = 64; exp2_c = 64;
            exp1_de = 1'b0; exp2_de = 1'b0;
            exp1_hs = 1'b0; exp2_hs = 1'b0;
        end else begin
            fall  = m_prev_h && !hsync;
            rise  = !m_prev_h && hsync;
            vrise = !m_prev_v && vsync;
            if (fall) begin
                m_ticks = 0;
                m_seen_fall = 1'b1;
            end else begin
                m_ticks++;
            end
            if (vrise) m_alt = 1'b0;
            else if (rise) m_alt = !m_alt;
            pcv = (hsync || !m_seen_fall) ? 255 : ((m_ticks > 255) ? 255 : m_ticks);
            ev  = (m_ticks + 2 * int'(m_alt)) % 4;
            exp2_c = exp1_c; exp2_de = exp1_de; exp2_hs = exp1_hs;
            exp1_c  = model_sample(int'(y), int'(i), int'(q), de, hsync, vsync, pcv, ev);
            exp1_de = de;
            exp1_hs = hsync;
            m_prev_h = hsync;
            m_prev_v = vsync;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            if (rst) begin
                checkOutput("reset composite", int'(composite), 64);
                checkOutput("reset out_de", int'(out_de), 0);
                checkOutput("reset out_hsync", int'(out_hsync), 0);
            end else begin
                checkOutput("model composite", int'(composite), exp2_c);
                checkOutput("model out_de", int'(out_de), int'(exp2_de));
                checkOutput("model out_hsync", int'(out_hsync), int'(exp2_hs));
            end
        end
    end

    task automatic applyStimulus(input bit hv, input bit vv, input bit dv,
                                 input logic [7:0] yv, input logic [7:0] iv, input logic [7:0] qv);
        hsync = hv;
        vsync = vv;
        de    = dv;
        y     = yv;
        i     = iv;
        q     = qv;
        @(posedge clk);
        #1;
    endtask

    // One line: hsync for HS_LEN cycles, then de over a window after the burst.
    task automatic runLine(input string name, input logic [7:0] yv, input logic [7:0] iv,
                           input logic [7:0] qv, input int vs_from, input int vs_to);
        bit hv, vv, dv;
        for (int j = 0; j < LINE; j++) begin
            hv = (j < HS_LEN);
            vv = (j >= vs_from) && (j < vs_to);
            dv = (j >= DE_FROM) && (j < LINE - 4);
            applyStimulus(hv, vv, dv, yv, iv, qv);
            if (j >= 1 && lit[j-1] >= 0)
                checkOutput($sformatf("%s sample %0d", name, j - 1), int'(composite), lit[j-1]);
        end
        for (int n = 0; n < 128; n++) lit[n] = -1;
    endtask

    task automatic setLit4(input int base, input int a, input int b, input int c, input int d);
        lit[base] = a; lit[base+1] = b; lit[base+2] = c; lit[base+3] = d;
    endtask

    initial begin
        for (int n = 0; n < 128; n++) lit[n] = -1;
        @(posedge clk);
        #1;
        check_en = 1'b1;
        checkOutput("reset composite literal", int'(composite), 64);
        @(posedge clk);
        #1;
        rst = 1'b0;
        y = 8'd0; i = 8'd0; q = 8'd0;
        for (int n = 0; n < 6; n++) applyStimulus(0, 0, 0, 8'd0, 8'd0, 8'd0);
        checkOutput("idle after reset", int'(composite), 64);

        // Line A, alt=1: sync then burst 44,64,84,64 from pc=8, blank at pc=44.
        lit[3] = 0;
        setLit4(HS_LEN + 8, 44, 64, 84, 64);
        setLit4(HS_LEN + 40, 44, 64, 84, 64);
        lit[HS_LEN + 44] = 64;
        runLine("burst alt1", 8'd0, 8'd128, 8'd128, -1, -1);

        // Line B, alt=0: burst inverted, chroma on I.
        setLit4(HS_LEN + 8, 84, 64, 44, 64);
        setLit4(DE_FROM, 210, 160, 110, 160);
        runLine("chroma I", 8'd128, 8'd228, 8'd128, -1, -1);

        lit[DE_FROM] = 255; lit[DE_FROM+1] = 255; lit[DE_FROM+2] = 255;
        runLine("grey 255", 8'd255, 8'd128, 8'd128, -1, -1);

        setLit4(DE_FROM, 160, 110, 160, 210);
        runLine("chroma Q", 8'd128, 8'd128, 8'd28, -1, -1);

        lit[DE_FROM] = 64; lit[DE_FROM+1] = 64;
        runLine("grey 0", 8'd0, 8'd128, 8'd128, -1, -1);

        lit[DE_FROM] = 160; lit[DE_FROM+3] = 160;
        runLine("grey 128", 8'd128, 8'd128, 8'd128, -1, -1);

        // alt=1: pc=48 has e=2, pc=50 has e=0 (clamped high).
        lit[DE_FROM] = 192; lit[DE_FROM+2] = 255;
        runLine("clamp high", 8'd255, 8'd255, 8'd128, -1, -1);

        // alt=0: e=0 clamps to 0, e=2 gives 128.
        lit[DE_FROM] = 0; lit[DE_FROM+1] = 64; lit[DE_FROM+2] = 128;
        runLine("clamp low", 8'd0, 8'd0, 8'd128, -1, -1);

        // vsync rises with hsync: alt cleared instead of toggled, burst starts at 84.
        lit[5] = 0;
        setLit4(HS_LEN + 8, 84, 64, 44, 64);
        runLine("vsync with hsync", 8'd128, 8'd128, 8'd128, 0, HS_LEN);

        // alt toggles to 1, then a mid-burst vsync pulse clears it.
        lit[HS_LEN + 8] = 44;
        lit[40] = 0; lit[41] = 0; lit[42] = 0;
        lit[HS_LEN + 36] = 84;
        runLine("vsync mid-line", 8'd128, 8'd128, 8'd128, 40, 43);

        for (int j = 0; j < 26; j++)
            applyStimulus(j < HS_LEN, 0, 0, 8'd128, 8'd128, 8'd128);
        checkOutput("burst before reset", int'(composite), 84);
        rst = 1'b1;
        #1;
        checkOutput("async reset composite", int'(composite), 64);
        checkOutput("async reset out_de", int'(out_de), 0);
        checkOutput("async reset out_hsync", int'(out_hsync), 0);
        for (int n = 0; n < 3; n++) applyStimulus(0, 0, 0, 8'd0, 8'd0, 8'd0);
        rst = 1'b0;
        for (int n = 0; n < 10; n++) applyStimulus(0, 0, 0, 8'd0, 8'd0, 8'd0);
        checkOutput("blank after mid-line reset", int'(composite), 64);

        applyStimulus(0, 0, 0, 8'd0, 8'd0, 8'd0);
        applyStimulus(0, 0, 0, 8'd0, 8'd0, 8'd0);
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
